dvb_s2_cfg_master: RTL
======================

Name: dvb_s2_cfg_master

Overview:
Register-bus initiator that drives the DVB-S2 configuration register bank through its write/read port: wen/waddr/wdata/wstrb and ren/raddr/rdata. On a start pulse it captures a complete modulator profile and writes registers 0..10 in order. It then optionally reads each register back and compares it with the expected field-masked value. It sits between boot/control logic and the register bank, and replaces software-driven bring-up of the modulator.

Parameters:
C_S_AXI_DATA_WIDTH, 32, register data width; must be a multiple of 8.
OPT_MEM_ADDR_BITS, 10, register address width.
NUM_REGS, 11, registers written and verified, at addresses 0..NUM_REGS-1.
SETTLE_CYCLES, 2, idle cycles between the last write and the first read.
VERIFY_EN, 1, 1 = perform read-back verification; 0 = skip directly to done.

Ports:
clk  in  1  single clock for all logic.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle request; ignored while busy=1.
mod_mode_cfg  in  2  profile field, register 0.
ldpc_mode_cfg  in  4  profile field, register 1.
frame_mode_cfg  in  1  profile field, register 2.
pilot_mode_cfg  in  1  profile field, register 3.
srrc_mode  in  2  profile field, register 4.
dvb_s_convolution_mode  in  3  profile field, register 5.
dvb_s_mode  in  1  profile field, register 6.
TS_Source_mode  in  2  profile field, register 7.
SYS_Baud_Num  in  32  profile field, register 8.
Freq_Inv_mode  in  1  profile field, register 9.
fs_en_switch  in  1  profile field, register 10.
wen  out  1  write strobe.
waddr  out  OPT_MEM_ADDR_BITS  write address.
wdata  out  C_S_AXI_DATA_WIDTH  write data, zero-extended field.
wstrb  out  C_S_AXI_DATA_WIDTH/8  byte enables; all ones whenever wen=1.
ren  out  1  read strobe.
raddr  out  OPT_MEM_ADDR_BITS  read address.
rdata  in  C_S_AXI_DATA_WIDTH  read data, valid in the cycle after ren.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse at sequence end.
err  out  1  sticky mismatch flag; cleared by the next accepted start.
err_addr  out  OPT_MEM_ADDR_BITS  address of the first mismatch.
err_count  out  4  number of mismatches, saturating at 15.

Behaviour:
- Reset values: every output is 0, including wstrb. The FSM returns to IDLE. A reset mid-sequence aborts it with no done pulse.
- start accepted in IDLE: all profile fields are latched into a shadow; err, err_addr and err_count are cleared; busy goes to 1; state goes to WRITE with idx=0.
- start in any other state has no effect. Profile inputs may change freely after acceptance.
- WRITE: one write per cycle. wen=1, waddr=idx, wdata=zero-extended shadow field[idx], wstrb=all ones.
- Write run: idx runs 0..NUM_REGS-1, so there are NUM_REGS consecutive wen cycles. After the last one, go to SETTLE if VERIFY_EN=1, otherwise DONE.
- SETTLE: wen=ren=0 for SETTLE_CYCLES cycles; this covers the bank's registered write path. Then go to READ with idx=0.
- READ, pipelined: ren=1 and raddr=idx on each of NUM_REGS consecutive cycles.
- Compare pipeline: a one-stage pipeline carries (valid, addr). In the cycle after each ren, rdata is compared with expected(addr).
- Expected value: the zero-extended shadow field. Bits above the field width must read 0.
- DRAIN: one cycle after the last ren completes the final compare. Then go to DONE.
- Mismatch: err is set. err_addr is loaded only on the first mismatch. err_count increments and saturates at 15.
- DONE: done=1 and busy=0 in the same cycle. Return to IDLE next cycle; a new start is accepted from IDLE only.
- Latency with VERIFY_EN=1: done asserts 1 + NUM_REGS + SETTLE_CYCLES + NUM_REGS + 1 cycles after start, which is 26 cycles at the defaults.
- Latency with VERIFY_EN=0: done asserts NUM_REGS + 1 cycles after start.
- wen and ren are never asserted in the same cycle.

Decomposition:
- Package dvb_s2_cfg_pkg holds:
  - register address constants REG_MOD_MODE=0 .. REG_FS_EN_SWITCH=10;
  - per-register field widths;
  - FSM state encoding IDLE, WRITE, SETTLE, READ, DRAIN, DONE.
- Sub-module dvb_s2_cfg_expect: a combinational mux from shadow and address to the zero-extended C_S_AXI_DATA_WIDTH value. The write path and the compare path share one instance each.

Test Plan:
- Default profile (ldpc=6, srrc=2, dvb_s_mode=1, TS=2, baud=2500, fs_en_switch=1, others 0) driven into a bank model, start pulsed -> 11 writes with wdata 0,6,0,0,2,0,1,2,2500,0,1; done at cycle 26; err=0.
- Bank model forces reg 8 read as 2501 -> err=1, err_addr=8, err_count=1, done still pulses.
- Bank model returns 0xFFFFFFFF for every read -> err_addr=0, err_count=11.
- start re-pulsed during WRITE at idx=4 -> ignored: exactly 11 writes, one done.
- rst asserted during READ -> next cycle all outputs 0, no done. A new start then runs the full sequence cleanly.
- VERIFY_EN=0 -> 11 writes, no ren, done at cycle 12.

Source files
------------

// File: rtl/dvb_s2_cfg_pkg.sv
// Shared definitions for the DVB-S2 configuration master.
// Holds the register map, the width of the field behind each register,
// the sequencer state encoding and the captured profile structure.
package dvb_s2_cfg_pkg;

    // Register addresses in the configuration bank
    localparam int REG_MOD_MODE      = 0;
    localparam int REG_LDPC_MODE     = 1;
    localparam int REG_FRAME_MODE    = 2;
    localparam int REG_PILOT_MODE    = 3;
    localparam int REG_SRRC_MODE     = 4;
    localparam int REG_CONV_MODE     = 5;
    localparam int REG_DVBS_MODE     = 6;
    localparam int REG_TS_SRC_MODE   = 7;
    localparam int REG_BAUD_NUM      = 8;
    localparam int REG_FREQ_INV_MODE = 9;
    localparam int REG_FS_EN_SWITCH  = 10;

    // Implemented field width behind each register
    localparam int W_MOD_MODE      = 2;
    localparam int W_LDPC_MODE     = 4;
    localparam int W_FRAME_MODE    = 1;
    localparam int W_PILOT_MODE    = 1;
    localparam int W_SRRC_MODE     = 2;
    localparam int W_CONV_MODE     = 3;
    localparam int W_DVBS_MODE     = 1;
    localparam int W_TS_SRC_MODE   = 2;
    localparam int W_BAUD_NUM      = 32;
    localparam int W_FREQ_INV_MODE = 1;
    localparam int W_FS_EN_SWITCH  = 1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SETTLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // One complete modulator profile, captured on an accepted start
    typedef struct packed {
        logic [W_MOD_MODE-1:0]      mod_mode;
        logic [W_LDPC_MODE-1:0]     ldpc_mode;
        logic [W_FRAME_MODE-1:0]    frame_mode;
        logic [W_PILOT_MODE-1:0]    pilot_mode;
        logic [W_SRRC_MODE-1:0]     srrc_mode;
        logic [W_CONV_MODE-1:0]     conv_mode;
        logic [W_DVBS_MODE-1:0]     dvbs_mode;
        logic [W_TS_SRC_MODE-1:0]   ts_src_mode;
        logic [W_BAUD_NUM-1:0]      baud_num;
        logic [W_FREQ_INV_MODE-1:0] freq_inv_mode;
        logic [W_FS_EN_SWITCH-1:0]  fs_en_switch;
    } profile_t;

endpackage

// File: rtl/dvb_s2_cfg_master_if.sv
// Register-bank access port: a write channel (wen/waddr/wdata/wstrb) and a
// read channel (ren/raddr) whose rdata returns in the cycle after ren.
//   master : drives strobes, addresses, write data; samples rdata
//   slave  : the register bank side
interface dvb_s2_cfg_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic                  wen;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  ren;
    logic [ADDR_W-1:0]     raddr;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output wen, waddr, wdata, wstrb, ren, raddr,
        input  rdata
    );

    modport slave (
        input  wen, waddr, wdata, wstrb, ren, raddr,
        output rdata
    );
endinterface

// File: rtl/dvb_s2_cfg_expect.sv
// Maps a register address to the zero-extended value of the matching
// profile field. Unmapped addresses yield zero.
//   prof : captured profile
//   addr : register address
//   data : field value, zero-extended to DW bits
module dvb_s2_cfg_expect
    import dvb_s2_cfg_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  profile_t        prof,
    input  logic [AW-1:0]   addr,
    output logic [DW-1:0]   data
);

    always_comb begin
        data = '0;
        case (addr)
            AW'(REG_MOD_MODE):      data = DW'(prof.mod_mode);
            AW'(REG_LDPC_MODE):     data = DW'(prof.ldpc_mode);
            AW'(REG_FRAME_MODE):    data = DW'(prof.frame_mode);
            AW'(REG_PILOT_MODE):    data = DW'(prof.pilot_mode);
            AW'(REG_SRRC_MODE):     data = DW'(prof.srrc_mode);
            AW'(REG_CONV_MODE):     data = DW'(prof.conv_mode);
            AW'(REG_DVBS_MODE):     data = DW'(prof.dvbs_mode);
            AW'(REG_TS_SRC_MODE):   data = DW'(prof.ts_src_mode);
            AW'(REG_BAUD_NUM):      data = DW'(prof.baud_num);
            AW'(REG_FREQ_INV_MODE): data = DW'(prof.freq_inv_mode);
            AW'(REG_FS_EN_SWITCH):  data = DW'(prof.fs_en_switch);
            default:                data = '0;
        endcase
    end

endmodule

// File: rtl/dvb_s2_cfg_master.sv
// DVB-S2 configuration master. On start it captures the modulator profile,
// writes registers 0..NUM_REGS-1 in order, waits SETTLE_CYCLES, then
// (VERIFY_EN=1) reads every register back and compares against the
// zero-extended captured field.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, accepted only in IDLE
//   *_cfg etc : profile fields, sampled on accepted start
//   bus       : register-bank write/read port (master side)
//   busy/done : sequence in progress / one-cycle end pulse
//   err, err_addr, err_count : sticky verify result
module dvb_s2_cfg_master
    import dvb_s2_cfg_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int OPT_MEM_ADDR_BITS  = 10,
    parameter int NUM_REGS           = 11,
    parameter int SETTLE_CYCLES      = 2,
    parameter int VERIFY_EN          = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   mod_mode_cfg,
    input  logic [3:0]                   ldpc_mode_cfg,
    input  logic                         frame_mode_cfg,
    input  logic                         pilot_mode_cfg,
    input  logic [1:0]                   srrc_mode,
    input  logic [2:0]                   dvb_s_convolution_mode,
    input  logic                         dvb_s_mode,
    input  logic [1:0]                   TS_Source_mode,
    input  logic [31:0]                  SYS_Baud_Num,
    input  logic                         Freq_Inv_mode,
    input  logic                         fs_en_switch,
    dvb_s2_cfg_master_if.master          bus,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [OPT_MEM_ADDR_BITS-1:0] err_addr,
    output logic [3:0]                   err_count
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = OPT_MEM_ADDR_BITS;
    localparam logic [AW-1:0] LAST_IDX    = AW'(NUM_REGS - 1);
    localparam logic [7:0]    LAST_SETTLE = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [7:0]      settle_cnt;
    profile_t        prof_in;
    profile_t        shadow;
    logic            cmp_vld;
    logic [AW-1:0]   cmp_addr;
    logic [DW-1:0]   wr_exp;
    logic [DW-1:0]   rd_exp;
    logic            accept;

    assign prof_in = '{
        mod_mode:      mod_mode_cfg,
        ldpc_mode:     ldpc_mode_cfg,
        frame_mode:    frame_mode_cfg,
        pilot_mode:    pilot_mode_cfg,
        srrc_mode:     srrc_mode,
        conv_mode:     dvb_s_convolution_mode,
        dvbs_mode:     dvb_s_mode,
        ts_src_mode:   TS_Source_mode,
        baud_num:      SYS_Baud_Num,
        freq_inv_mode: Freq_Inv_mode,
        fs_en_switch:  fs_en_switch
    };

    assign accept = (state == IDLE) && start;

    dvb_s2_cfg_expect #(.DW(DW), .AW(AW)) u_wr_exp (
        .prof (shadow),
        .addr (bus.waddr),
        .data (wr_exp)
    );

    dvb_s2_cfg_expect #(.DW(DW), .AW(AW)) u_rd_exp (
        .prof (shadow),
        .addr (cmp_addr),
        .data (rd_exp)
    );

    // wdata is decoded from registered shadow/waddr and gated by the
    // registered wen, so it is clean and reads 0 whenever no write is issued.
    assign bus.wdata = bus.wen ? wr_exp : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            shadow     <= '0;
            bus.wen    <= 1'b0;
            bus.waddr  <= '0;
            bus.wstrb  <= '0;
            bus.ren    <= 1'b0;
            bus.raddr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            bus.wen   <= 1'b0;
            bus.wstrb <= '0;
            bus.ren   <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow    <= prof_in;
                        busy      <= 1'b1;
                        idx       <= '0;
                        state     <= WRITE;
                        bus.wen   <= 1'b1;
                        bus.waddr <= '0;
                        bus.wstrb <= '1;
                    end
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        idx        <= '0;
                        settle_cnt <= '0;
                        if (VERIFY_EN == 0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (SETTLE_CYCLES == 0) begin
                            state     <= READ;
                            bus.ren   <= 1'b1;
                            bus.raddr <= '0;
                        end else begin
                            state <= SETTLE;
                        end
                    end else begin
                        idx       <= idx + 1'b1;
                        bus.wen   <= 1'b1;
                        bus.waddr <= idx + 1'b1;
                        bus.wstrb <= '1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == LAST_SETTLE) begin
                        state     <= READ;
                        bus.ren   <= 1'b1;
                        bus.raddr <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                READ: begin
                    if (idx == LAST_IDX) begin
                        state <= DRAIN;
                    end else begin
                        idx       <= idx + 1'b1;
                        bus.ren   <= 1'b1;
                        bus.raddr <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    // last read's data is compared this cycle
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // One-stage compare pipe: (valid, addr) follows ren/raddr by one cycle,
    // lining up with the bank's rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_vld   <= 1'b0;
            cmp_addr  <= '0;
            err       <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            cmp_vld  <= bus.ren;
            cmp_addr <= bus.raddr;
            if (accept) begin
                err       <= 1'b0;
                err_addr  <= '0;
                err_count <= '0;
            end else if (cmp_vld && (bus.rdata != rd_exp)) begin
                err <= 1'b1;
                if (!err)
                    err_addr <= cmp_addr;
                if (err_count != 4'hF)
                    err_count <= err_count + 4'd1;
            end
        end
    end

endmodule
